// File: rtl/instruction_decode_stage_pkg.sv
// Shared RV32I decode definitions: opcodes, control enums and the bubble instruction.
package riscv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctrl_t;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_t;

endpackage

// File: rtl/instruction_decode_stage_register_file.sv
// 32x32 register file: async clear, one write port, two combinational read ports.
// Optional same-cycle write-to-read bypass under REGFILE_BYPASS_EN.
module register_file (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2
);

    logic [31:0] regs [32];
    logic        wr_active;

    assign wr_active = we && (waddr != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_active) begin
            regs[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
`ifdef REGFILE_BYPASS_EN
        if (raddr1 == '0)                      rdata1 = '0;
        else if (wr_active && raddr1 == waddr) rdata1 = wdata;
        else                                   rdata1 = regs[raddr1];
        if (raddr2 == '0)                      rdata2 = '0;
        else if (wr_active && raddr2 == waddr) rdata2 = wdata;
        else                                   rdata2 = regs[raddr2];
`else
        if (raddr1 != '0) rdata1 = regs[raddr1];
        if (raddr2 != '0) rdata2 = regs[raddr2];
`endif
    end

endmodule

// File: rtl/instruction_decode_stage.sv
// RV32I decode stage: IF/ID register, main/ALU decoders, immediate extender, register file.
// Define REGFILE_BYPASS_EN to forward a writeback value to same-cycle reads.
module instruction_decode_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic [31:0] InstrF,
    input  logic [31:0] PCF,
    input  logic [31:0] PCPlus4F,
    input  logic        RegWriteW,
    input  logic [4:0]  RdW,
    input  logic [31:0] ResultW,
    output logic [31:0] RD1D,
    output logic [31:0] RD2D,
    output logic [31:0] ImmExtD,
    output logic [4:0]  Rs1D,
    output logic [4:0]  Rs2D,
    output logic [4:0]  RdD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        RegWriteD,
    output logic        MemWriteD,
    output logic        JumpD,
    output logic        BranchD,
    output logic        ALUSrcD,
    output logic [1:0]  ResultSrcD,
    output logic [2:0]  ALUControlD,
    output logic        IllegalD
);

    logic [31:0] instr_d;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
    imm_src_t    imm_src;
    logic        imm_en;
    result_src_t result_src;
    alu_ctrl_t   alu_ctrl;
    logic        illegal_op;
    logic        funct3_bad;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_d  <= NOP_INSTR;
            PCD      <= '0;
            PCPlus4D <= '0;
        end else if (FlushD) begin
            instr_d  <= NOP_INSTR;
            PCD      <= '0;
            PCPlus4D <= '0;
        end else if (!StallD) begin
            instr_d  <= InstrF;
            PCD      <= PCF;
            PCPlus4D <= PCPlus4F;
        end
    end

    assign opcode   = instr_d[6:0];
    assign funct3   = instr_d[14:12];
    assign funct7b5 = instr_d[30];
    assign Rs1D     = instr_d[19:15];
    assign Rs2D     = instr_d[24:20];
    assign RdD      = instr_d[11:7];

    always_comb begin
        RegWriteD  = 1'b0;
        MemWriteD  = 1'b0;
        JumpD      = 1'b0;
        BranchD    = 1'b0;
        ALUSrcD    = 1'b0;
        result_src = RES_ALU;
        imm_src    = IMM_I;
        imm_en     = 1'b0;
        illegal_op = 1'b0;
        case (opcode)
            OP_LOAD:   begin RegWriteD = 1'b1; ALUSrcD = 1'b1; result_src = RES_MEM; imm_en = 1'b1; end
            OP_STORE:  begin MemWriteD = 1'b1; ALUSrcD = 1'b1; imm_src = IMM_S; imm_en = 1'b1; end
            OP_RTYPE:  begin RegWriteD = 1'b1; end
            OP_IALU:   begin RegWriteD = 1'b1; ALUSrcD = 1'b1; imm_en = 1'b1; end
            OP_BRANCH: begin BranchD = 1'b1; imm_src = IMM_B; imm_en = 1'b1; end
            OP_JAL:    begin RegWriteD = 1'b1; JumpD = 1'b1; result_src = RES_PC4; imm_src = IMM_J; imm_en = 1'b1; end
            default:   illegal_op = 1'b1;
        endcase
    end

    always_comb begin
        alu_ctrl   = ALU_ADD;
        funct3_bad = 1'b0;
        if (opcode == OP_BRANCH) begin
            alu_ctrl = ALU_SUB;
        end else if (opcode == OP_RTYPE || opcode == OP_IALU) begin
            case (funct3)
                3'b000:  alu_ctrl = (opcode == OP_RTYPE && funct7b5) ? ALU_SUB : ALU_ADD;
                3'b010:  alu_ctrl = ALU_SLT;
                3'b110:  alu_ctrl = ALU_OR;
                3'b111:  alu_ctrl = ALU_AND;
                default: funct3_bad = 1'b1;
            endcase
        end
    end

    always_comb begin
        ImmExtD = '0;
        if (imm_en) begin
            case (imm_src)
                IMM_I: ImmExtD = {{20{instr_d[31]}}, instr_d[31:20]};
                IMM_S: ImmExtD = {{20{instr_d[31]}}, instr_d[31:25], instr_d[11:7]};
                IMM_B: ImmExtD = {{20{instr_d[31]}}, instr_d[7], instr_d[30:25], instr_d[11:8], 1'b0};
                IMM_J: ImmExtD = {{12{instr_d[31]}}, instr_d[19:12], instr_d[20], instr_d[30:21], 1'b0};
                default: ImmExtD = '0;
            endcase
        end
    end

    assign ResultSrcD  = result_src;
    assign ALUControlD = alu_ctrl;
    assign IllegalD    = illegal_op | funct3_bad;

    register_file u_register_file (
        .clk    (clk),
        .rst    (rst),
        .we     (RegWriteW),
        .waddr  (RdW),
        .wdata  (ResultW),
        .raddr1 (Rs1D),
        .raddr2 (Rs2D),
        .rdata1 (RD1D),
        .rdata2 (RD2D)
    );

endmodule

// File: doc/instruction_decode_stage.md
# instruction_decode_stage

Second stage of the five-stage RV32I pipeline, directly downstream of the fetch stage. It captures `InstrF`, `PCF` and `PCPlus4F` in the IF/ID pipeline register, which honours stall and flush. It decodes the held instruction into control signals and register indices, and sign-extends the immediate. It also contains the 32×32 register file, which the writeback stage writes.

## Interface
- `NOP_INSTR`, default `32'h0000_0013`: instruction loaded into the IF/ID register on reset or flush (`ADDI x0,x0,0`).
- `clk  in  1`: clock.
- `rst  in  1`: reset, asynchronous, active-high.
- `StallD  in  1`: hold the IF/ID register.
- `FlushD  in  1`: load a bubble into the IF/ID register.
- `InstrF, PCF, PCPlus4F  in  32 each`: fetch-stage outputs.
- `RegWriteW  in  1`: register-file write enable from writeback.
- `RdW  in  5`: write index.
- `ResultW  in  32`: write data.
- `RD1D, RD2D  out  32`: register reads for rs1 and rs2.
- `ImmExtD  out  32`: sign-extended immediate.
- `Rs1D, Rs2D, RdD  out  5`: register indices, forwarded to the hazard unit.
- `PCD, PCPlus4D  out  32`: registered PC values.
- `RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD  out  1`: control.
- `ResultSrcD  out  2`: result select; 00 = ALU, 01 = memory, 10 = PC+4.
- `ALUControlD  out  3`: ALU operation; 000 add, 001 sub, 010 and, 011 or, 101 slt.
- `IllegalD  out  1`: the opcode held in IF/ID is not supported.

## Operation
- **IF/ID register** priority: `rst` > `FlushD` > `StallD` > load.
  - Reset or flush: `InstrD = NOP_INSTR`, `PCD = 0`, `PCPlus4D = 0`.
  - Stall: all three registers hold.
  - Otherwise: all three load from the fetch stage.
- **Index extraction:** `Rs1D = InstrD[19:15]`, `Rs2D = InstrD[24:20]`, `RdD = InstrD[11:7]`.
- **Main decoder**, by opcode:
  - lw (0000011): RegWrite, ALUSrc, ResultSrc 01, imm type I.
  - sw (0100011): MemWrite, ALUSrc, imm type S.
  - R-type (0110011): RegWrite.
  - I-ALU (0010011): RegWrite, ALUSrc, imm type I.
  - beq (1100011): Branch, ALU sub, imm type B.
  - jal (1101111): RegWrite, Jump, ResultSrc 10, imm type J.
  - Any other opcode, including `32'h0`: all control signals 0 and `IllegalD = 1`. The instruction behaves as a bubble.
- **ALU decoder** uses funct3 and funct7[5]:
  - add/addi → add; sub (R-type with funct7[5] = 1) → sub.
  - slt/slti → slt; or/ori → or; and/andi → and.
  - Memory and jal instructions → add.
  - Unsupported funct3 → add with `IllegalD = 1`.
- **Immediate extension**, always sign-extended from instruction bit 31:
  - I: `[31:20]`.
  - S: `{[31:25],[11:7]}`.
  - B: `{[31],[7],[30:25],[11:8],0}`.
  - J: `{[31],[19:12],[20],[30:21],0}`.
  - Unused type: 0.
- **Register file:** 32×32. Reads are combinational.
  - Writes happen on the posedge of `clk` when `RegWriteW = 1` and `RdW != 0`.
  - x0 always reads 0.
  - `rst` clears all registers asynchronously.

## Timing
- IF/ID latency is 1 cycle. All decode outputs are combinational from the IF/ID contents.
- Reset values of the outputs:
  - The decode of `NOP_INSTR`: `RegWriteD = 1`, `ALUSrcD = 1`, `RdD = 0`, `ImmExtD = 0`, `IllegalD = 0`.
  - `PCD = PCPlus4D = 0`.
  - `RD1D = RD2D = 0`.
- Flush and stall asserted in the same cycle: flush wins.
- `rst` asserted mid-operation: IF/ID and the register file clear immediately, without waiting for a clock edge.
- A register-file write lands at the edge that closes the writeback cycle. For a same-cycle read of that register, see Configuration.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - A read whose index equals `RdW` returns `ResultW` combinationally in the same cycle, provided `RegWriteW = 1` and `RdW != 0`.
  - Bypass applies independently to the rs1 and rs2 ports.
- `REGFILE_BYPASS_EN` undefined:
  - Reads return the stored value, so the write is visible from the next cycle.
  - The hazard unit must stall one extra cycle for that case.

## Structure
- A shared package `riscv_pkg` holds:
  - The opcode constants.
  - Enum `imm_src_t` (I, S, B, J).
  - Enum `alu_ctrl_t`.
  - Enum `result_src_t`.
  - `NOP_INSTR`.
- One sub-module, `register_file`, contains the array, the reset, the write port, the two read ports and the bypass logic.
- The decoders and the immediate extender are `always_comb` blocks in the top module.

## Test plan
- **Reset:** assert `rst` → `InstrD = 32'h13`, `IllegalD = 0`, and `RD1D = 0` for `Rs1D = 5`.
- **ADDI:** load `InstrF = 32'h00100113` (addi x2,x0,1) → next cycle `RegWriteD = 1`, `ALUSrcD = 1`, `RdD = 2`, `ImmExtD = 1`, `ALUControlD = 000`.
- **Negative immediate and store:**
  - `32'hFFF00093` → `ImmExtD = 32'hFFFFFFFF`.
  - `32'h0020A223` (sw x2,4(x1)) → `MemWriteD = 1`, `ImmExtD = 4`, `Rs1D = 1`, `Rs2D = 2`.
- **Writeback:**
  - Write x5 = `32'hDEADBEEF` → it reads back on the following cycle.
  - Write x0 = 7 → x0 still reads 0.
  - With `REGFILE_BYPASS_EN` defined, a same-cycle read of x5 returns `DEADBEEF`.
- **Stall/flush:**
  - `StallD` held for 3 cycles while `InstrF` changes → `InstrD`/`PCD` hold.
  - `FlushD` and `StallD` asserted together → NOP, `PCD = 0`.
- **Illegal opcode:** `InstrF = 32'h0` → `IllegalD = 1` and all control signals 0.
